// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - shared state encoding and default timing constants for the button event decoder
package button_event_pkg;

    typedef enum logic [1:0] {
        LOCKOUT = 2'd0,
        IDLE    = 2'd1,
        HELD    = 2'd2,
        LONG    = 2'd3
    } state_t;

    localparam int DEF_LONG_CYCLES   = 50_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;
    localparam int DEF_CNT_W         = 26;

endpackage

// File: rtl/button_event_decoder_hold_timer.sv
// rtl/button_event_decoder_hold_timer.sv - loadable hold up-counter with terminal-count compare
module hold_timer
    import button_event_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_terminal,
    output logic             o_hit
);

    logic [CNT_W-1:0] r_count;

    // Clear wins over load, load wins over increment.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CNT_W'(1);
        end else if (i_inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_hit = (r_count == i_terminal);

endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - debounced level to press/release/long/repeat strobes; BUTTON_EVENT_REPEAT_EN enables auto-repeat
module button_event_decoder
    import button_event_pkg::*;
#(
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_pressed,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_release_long,
    output logic o_long_pulse,
    output logic o_repeat_pulse
);

    state_t r_state;
    state_t w_next;
    logic   r_lvl_q;
    logic   r_pressed, r_press, r_release, r_release_long, r_long;
    logic   w_pressed, w_press, w_release, w_release_long, w_long, w_repeat;
    logic   w_clear, w_load, w_inc, w_hit, w_rise, w_fall;
    logic [CNT_W-1:0] w_terminal;

    assign w_rise     = i_level & ~r_lvl_q;
    assign w_fall     = ~i_level & r_lvl_q;
    assign w_terminal = (r_state == LONG) ? CNT_W'(REPEAT_CYCLES) : CNT_W'(LONG_CYCLES);

    hold_timer #(.CNT_W(CNT_W)) u_hold_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (w_clear),
        .i_load     (w_load),
        .i_inc      (w_inc),
        .i_terminal (w_terminal),
        .o_hit      (w_hit)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= LOCKOUT;
            r_lvl_q <= 1'b0;
        end else begin
            r_state <= w_next;
            r_lvl_q <= i_level;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LOCKOUT: if (!i_level) w_next = IDLE;
            IDLE:    if (w_rise) w_next = HELD;
            HELD: begin
                if (w_fall)     w_next = IDLE;
                else if (w_hit) w_next = LONG;
            end
            LONG:    if (w_fall) w_next = IDLE;
            default: w_next = LOCKOUT;
        endcase
    end

    // Release is checked first so it suppresses a coincident long/repeat hit.
    always_comb begin
        w_pressed      = r_pressed;
        w_press        = 1'b0;
        w_release      = 1'b0;
        w_release_long = 1'b0;
        w_long         = 1'b0;
        w_repeat       = 1'b0;
        w_clear        = 1'b0;
        w_load         = 1'b0;
        w_inc          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_press   = 1'b1;
                    w_pressed = 1'b1;
                    w_load    = 1'b1;
                end
            end
            HELD: begin
                if (w_fall) begin
                    w_release = 1'b1;
                    w_pressed = 1'b0;
                    w_clear   = 1'b1;
                end else if (w_hit) begin
                    w_long = 1'b1;
                    w_load = 1'b1;
                end else begin
                    w_inc = 1'b1;
                end
            end
            LONG: begin
                if (w_fall) begin
                    w_release      = 1'b1;
                    w_release_long = 1'b1;
                    w_pressed      = 1'b0;
                    w_clear        = 1'b1;
                end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
                    if (w_hit) begin
                        w_repeat = 1'b1;
                        w_load   = 1'b1;
                    end else begin
                        w_inc = 1'b1;
                    end
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pressed      <= 1'b0;
            r_press        <= 1'b0;
            r_release      <= 1'b0;
            r_release_long <= 1'b0;
            r_long         <= 1'b0;
        end else begin
            r_pressed      <= w_pressed;
            r_press        <= w_press;
            r_release      <= w_release;
            r_release_long <= w_release_long;
            r_long         <= w_long;
        end
    end

`ifdef BUTTON_EVENT_REPEAT_EN
    logic r_repeat;
    always_ff @(posedge i_clk) begin
        if (i_rst) r_repeat <= 1'b0;
        else       r_repeat <= w_repeat;
    end
    assign o_repeat_pulse = r_repeat;
`else
    logic w_unused_repeat;
    assign w_unused_repeat = w_repeat;
    assign o_repeat_pulse  = 1'b0;
`endif

    assign o_pressed       = r_pressed;
    assign o_press_pulse   = r_press;
    assign o_release_pulse = r_release;
    assign o_release_long  = r_release_long;
    assign o_long_pulse    = r_long;

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - scoreboard bench for button_event_decoder
module tb_button_event_decoder;

    localparam int LC = 8;
    localparam int RC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic level = 1'b0;
    logic pressed, press_pulse, release_pulse, release_long, long_pulse, repeat_pulse;

    button_event_decoder #(.LONG_CYCLES(LC), .REPEAT_CYCLES(RC), .CNT_W(4)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_level         (level),
        .o_pressed       (pressed),
        .o_press_pulse   (press_pulse),
        .o_release_pulse (release_pulse),
        .o_release_long  (release_long),
        .o_long_pulse    (long_pulse),
        .o_repeat_pulse  (repeat_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 press, 1 release, 2 long, 3 repeat
    typedef struct {
        int   kind;
        int   cyc;
        logic rl;
    } ev_t;
    ev_t q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int c, input logic rl);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.rl   = rl;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold level high for n sampled cycles starting at the next edge, then drop it.
    task automatic hold(input int n);
        int r;
        r = cyc;
        push(0, r + 1, 1'b0);
        if (n >= LC + 1) begin
            push(2, r + 1 + LC, 1'b0);
`ifdef BUTTON_EVENT_REPEAT_EN
            for (int t = r + 1 + LC + RC; t <= r + n; t += RC) push(3, t, 1'b0);
`endif
        end
        push(1, r + n + 1, (n >= LC + 1) ? 1'b1 : 1'b0);
        level = 1'b1;
        tick(n);
        level = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        chk({tag, "_pressed"}, int'(pressed), 0);
        chk({tag, "_press"}, int'(press_pulse), 0);
        chk({tag, "_release"}, int'(release_pulse), 0);
        chk({tag, "_release_long"}, int'(release_long), 0);
        chk({tag, "_long"}, int'(long_pulse), 0);
        chk({tag, "_repeat"}, int'(repeat_pulse), 0);
    endtask

    always @(negedge clk) begin
        int n;
        int kind;
        ev_t e;
        if (release_long && !release_pulse) chk("release_long_alone", 1, 0);
        n = int'(press_pulse) + int'(release_pulse) + int'(long_pulse) + int'(repeat_pulse);
        if (n != 0) begin
            kind = press_pulse ? 0 : release_pulse ? 1 : long_pulse ? 2 : 3;
            chk("exclusive", n, 1);
            if (q.size() == 0) begin
                chk("unexpected_event", kind, -1);
            end else begin
                e = q.pop_front();
                chk("kind", kind, e.kind);
                chk("cycle", cyc, e.cyc);
                chk("release_long", int'(release_long), (kind == 1) ? int'(e.rl) : 0);
                chk("pressed", int'(pressed), (kind == 1) ? 0 : 1);
            end
        end
    end

    initial begin
        rst = 1'b1;
        level = 1'b0;
        tick(2);
        check_all_zero("reset");
        rst = 1'b0;
        tick(4);

        hold(5);            // short press
        tick(4);
        hold(20);           // long press, repeats when enabled
        tick(4);
        hold(1);            // one-cycle glitch
        tick(3);
        hold(LC);           // release coincides with terminal count
        tick(3);

        level = 1'b1;       // held through reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(10);
        @(negedge clk);
        chk("lockout_pressed", int'(pressed), 0);
        level = 1'b0;
        tick(1);
        hold(3);
        tick(3);

        push(0, cyc + 1, 1'b0);   // reset mid-hold
        level = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        check_all_zero("midhold");
        rst = 1'b0;
        tick(3);
        @(negedge clk);
        chk("midhold_lockout_pressed", int'(pressed), 0);
        level = 1'b0;
        tick(2);
        hold(1);
        tick(4);

        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the clean, debounced button level and turns it into one-cycle event strobes: press, release, long-press and (optionally) auto-repeat.
- Sits directly downstream of the debouncer and acts as the reader of its output.
- Drives the UI/control logic, which never has to time button holds itself.
- All outputs are registered.

Parameters:
- LONG_CYCLES, default 50_000_000: hold time, in clk cycles, from press_pulse to long_pulse. Legal range ≥ 2.
- REPEAT_CYCLES, default 10_000_000: period, in clk cycles, of repeat_pulse while held after a long press. Legal range ≥ 1.
- CNT_W, default 26: hold-counter width. Must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
- clk  in  1  system clock; the single clock domain.
- rst  in  1  synchronous, active-high reset.
- level  in  1  debounced button level, already synchronous to clk; 1 = pressed.
- pressed  out  1  registered copy of the accepted button state.
- press_pulse  out  1  one-cycle strobe on an accepted press.
- release_pulse  out  1  one-cycle strobe on an accepted release.
- release_long  out  1  qualifies release_pulse: 1 if the release ended a hold that reached long_pulse.
- long_pulse  out  1  one-cycle strobe when the hold reaches LONG_CYCLES.
- repeat_pulse  out  1  one-cycle strobe every REPEAT_CYCLES after long_pulse. Tied 0 when the feature is compiled out.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state goes to LOCKOUT, hold counter clears to 0.
  - All outputs go to 0, including pressed.
  - lvl_q (the one-cycle delayed copy of level) goes to 0.
- States: LOCKOUT, IDLE, HELD, LONG.
- LOCKOUT:
  - Stays here while level=1, emitting no events. This means a button held through reset produces no press.
  - Moves to IDLE on the first cycle level=0.
- IDLE → HELD on level=1 & lvl_q=0.
  - press_pulse=1 and pressed=1 in the following cycle, i.e. 1-cycle latency from the rising sample.
  - Counter loads 1.
- HELD:
  - Counter increments each cycle while level=1.
  - When the counter equals LONG_CYCLES: long_pulse=1 for that one output cycle, counter reloads 1, state → LONG.
  - long_pulse is therefore exactly LONG_CYCLES cycles after press_pulse.
- LONG, with the feature enabled:
  - Counter increments each cycle.
  - When it equals REPEAT_CYCLES: repeat_pulse=1, counter reloads 1.
  - Without the feature: the counter is frozen.
- Release:
  - Trigger: level=0 & lvl_q=1 while in HELD or LONG.
  - Next cycle: release_pulse=1, pressed=0, state → IDLE, counter → 0.
  - release_long=1 together with release_pulse if the release left LONG, else 0. release_long is 0 whenever release_pulse is 0.
- Simultaneous events, release priority: if the release sample coincides with the counter hitting its terminal value, only release_pulse is emitted (no long_pulse or repeat_pulse).
- Pulse exclusivity: at most one of press_pulse, long_pulse, repeat_pulse, release_pulse is high in any cycle.
- Short glitches: a 1-cycle level pulse yields press_pulse followed 1 cycle later by release_pulse (release_long=0). The input is trusted as debounced; no filtering is done here.
- Counter arithmetic: unsigned, CNT_W bits. It never wraps, because it reloads at its terminal value.
- Reset mid-operation: overrides everything, no release_pulse is emitted, state → LOCKOUT.

Optional Feature:
- Macro: BUTTON_EVENT_REPEAT_EN.
- Defined: LONG runs the repeat timer as described above.
- Undefined:
  - repeat_pulse is tied 0.
  - LONG simply waits for release; the counter is idle at its reload value.
  - REPEAT_CYCLES is ignored.

Decomposition:
- Package button_event_pkg:
  - state enum (LOCKOUT, IDLE, HELD, LONG).
  - default constants for LONG_CYCLES, REPEAT_CYCLES, CNT_W.
- One sub-module, hold_timer:
  - Loadable CNT_W up-counter with a terminal-compare input and a one-cycle hit output.
  - Instantiated once and shared by the HELD and LONG phases.
- FSM and output registers live in the top module.

Test Plan:
All scenarios use bench parameters LONG_CYCLES=8, REPEAT_CYCLES=3, with the feature defined unless stated.
1. Short press: rst, level=0 for 4 cycles, level=1 for 5 cycles, then 0 → press_pulse 1 cycle after the rise, no long_pulse, release_pulse with release_long=0 1 cycle after the fall.
2. Long press with repeat: level=1 for 20 cycles → long_pulse 8 cycles after press_pulse, repeat_pulse at +3, +6, +9 after long_pulse, release_long=1 on release.
3. Feature undefined, same stimulus as scenario 2 → long_pulse at +8, repeat_pulse stays 0 throughout, release_long=1.
4. Held through reset: level=1 during and after rst for 10 cycles → no press_pulse. Then level=0 for 1 cycle and back to 1 → press_pulse.
5. Release at the terminal count: level falls on the cycle the counter would hit 8 → release_pulse=1, long_pulse never asserted, release_long=0.
6. Reset mid-hold: press, then assert rst at cycle 5 of the hold → all outputs 0 the next cycle, no release_pulse, state is LOCKOUT until level=0.
